// File: rtl/nr_fetch_pkg.sv
`default_nettype none
//==============================================================================
// Module      : nr_fetch_pkg
// Description : Shared widths, FSM state type and buffer entry type for the
//               nanoRisk instruction fetch stage.
// Revision    : 1.0  initial release
//==============================================================================
package nr_fetch_pkg;

    localparam int NR_ADDR_W = 4;
    localparam int NR_DATA_W = 8;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } nr_fetch_state_t;

    typedef struct packed {
        logic [NR_ADDR_W-1:0] pc;
        logic [NR_DATA_W-1:0] instr;
    } nr_fetch_entry_t;

endpackage : nr_fetch_pkg
`default_nettype wire

// File: rtl/nr_fetch_if.sv
`default_nettype none
//==============================================================================
// Module      : nr_fetch_if
// Description : Fetch-stage bundle: instruction memory read port, redirect and
//               halt controls, and the valid/ready handshake towards decode.
// Revision    : 1.0  initial release
//==============================================================================
interface nr_fetch_if
    import nr_fetch_pkg::*;
#(
    parameter int ADDR_W = NR_ADDR_W,
    parameter int DATA_W = NR_DATA_W
);
    logic [ADDR_W-1:0] f_adr_out;
    logic              f_can_rd;
    logic [DATA_W-1:0] f_mem_data;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halt;
    logic              instr_valid;
    logic [DATA_W-1:0] instr_data;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_ready;

    // Fetch unit side
    modport master (
        output f_adr_out, f_can_rd, instr_valid, instr_data, instr_pc,
        input  f_mem_data, redirect_valid, redirect_pc, halt, instr_ready
    );

    // Memory / control / decode side
    modport slave (
        input  f_adr_out, f_can_rd, instr_valid, instr_data, instr_pc,
        output f_mem_data, redirect_valid, redirect_pc, halt, instr_ready
    );
endinterface : nr_fetch_if
`default_nettype wire

// File: rtl/nr_fetch_fifo.sv
`default_nettype none
//==============================================================================
// Module      : nr_fetch_fifo
// Description : Two-entry prefetch buffer holding {pc, instr}. Slot 0 is always
//               the head; entries shift down on pop. Flush empties it.
// Revision    : 1.0  initial release
//==============================================================================
module nr_fetch_fifo
    import nr_fetch_pkg::*;
#(
    parameter int ADDR_W = NR_ADDR_W,
    parameter int DATA_W = NR_DATA_W
) (
    input  wire logic              clk,
    input  wire logic              clr,
    input  wire logic              i_push,
    input  wire logic              i_pop,
    input  wire logic              i_flush,
    input  wire logic [ADDR_W-1:0] i_push_pc,
    input  wire logic [DATA_W-1:0] i_push_instr,
    output logic                   o_head_valid,
    output logic      [ADDR_W-1:0] o_head_pc,
    output logic      [DATA_W-1:0] o_head_instr,
    output logic      [1:0]        o_count
);
    logic [ADDR_W-1:0] r_pc    [2];
    logic [DATA_W-1:0] r_instr [2];
    logic [1:0]        r_count;

    // Storage and occupancy; simultaneous push+pop keeps count and shifts in
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_count    <= 2'd0;
            r_pc[0]    <= '0;
            r_pc[1]    <= '0;
            r_instr[0] <= '0;
            r_instr[1] <= '0;
        end else if (i_flush) begin
            r_count <= 2'd0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_pc[0]    <= i_push_pc;
                        r_instr[0] <= i_push_instr;
                        r_count    <= 2'd1;
                    end else if (r_count == 2'd1) begin
                        r_pc[1]    <= i_push_pc;
                        r_instr[1] <= i_push_instr;
                        r_count    <= 2'd2;
                    end
                end
                2'b01: begin
                    if (r_count != 2'd0) begin
                        r_pc[0]    <= r_pc[1];
                        r_instr[0] <= r_instr[1];
                        r_count    <= r_count - 2'd1;
                    end
                end
                2'b11: begin
                    if (r_count == 2'd2) begin
                        r_pc[0]    <= r_pc[1];
                        r_instr[0] <= r_instr[1];
                        r_pc[1]    <= i_push_pc;
                        r_instr[1] <= i_push_instr;
                    end else begin
                        r_pc[0]    <= i_push_pc;
                        r_instr[0] <= i_push_instr;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Head presentation, zeroed when empty so decode never sees stale data
    always_comb begin
        o_head_valid = (r_count != 2'd0);
        o_head_pc    = o_head_valid ? r_pc[0]    : '0;
        o_head_instr = o_head_valid ? r_instr[0] : '0;
        o_count      = r_count;
    end

endmodule : nr_fetch_fifo
`default_nettype wire

// File: rtl/nr_fetch_unit.sv
`default_nettype none
//==============================================================================
// Module      : nr_fetch_unit
// Description : nanoRisk instruction fetch stage. Owns the PC, issues memory
//               reads, buffers returned instructions and hands {pc, instr} to
//               decode. Supports branch redirect and halt.
// Revision    : 1.0  initial release
//==============================================================================
module nr_fetch_unit
    import nr_fetch_pkg::*;
#(
    parameter int                ADDR_W    = NR_ADDR_W,
    parameter int                DATA_W    = NR_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                BUF_DEPTH = 2
) (
    input  wire logic  clk,
    input  wire logic  clr,
    nr_fetch_if.master fb
);
    nr_fetch_state_t   r_state;
    nr_fetch_state_t   w_state_next;
    logic [ADDR_W-1:0] r_pc;
    logic              w_can_rd;
    logic              w_push;
    logic              w_pop;
    logic              w_head_valid;
    logic [1:0]        w_count;

    assign w_pop = w_head_valid & fb.instr_ready;

    // FSM state register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and read issue; redirect overrides halt and returns to run
    always_comb begin
        w_state_next = r_state;
        w_can_rd     = 1'b0;
        w_push       = 1'b0;
        case (r_state)
            S_BOOT: w_state_next = S_RUN;
            S_RUN: begin
                w_can_rd = !fb.halt && ((w_count < 2'(BUF_DEPTH)) || w_pop);
                if (fb.halt) begin
                    w_state_next = S_HALT;
                end
            end
            S_HALT: w_state_next = S_HALT;
            default: w_state_next = S_BOOT;
        endcase
        if (fb.redirect_valid) begin
            w_state_next = S_RUN;
        end
        // A read issued in a redirect cycle returns data for the old path
        w_push = w_can_rd && !fb.redirect_valid;
    end

    // Program counter: redirect target, else advance on every issued read
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_pc <= RESET_PC;
        end else if (fb.redirect_valid) begin
            r_pc <= fb.redirect_pc;
        end else if (w_can_rd) begin
            r_pc <= r_pc + ADDR_W'(1);
        end
    end

    assign fb.f_adr_out = r_pc;
    assign fb.f_can_rd  = w_can_rd;

    nr_fetch_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk          (clk),
        .clr          (clr),
        .i_push       (w_push),
        .i_pop        (w_pop),
        .i_flush      (fb.redirect_valid),
        .i_push_pc    (r_pc),
        .i_push_instr (fb.f_mem_data),
        .o_head_valid (w_head_valid),
        .o_head_pc    (fb.instr_pc),
        .o_head_instr (fb.instr_data),
        .o_count      (w_count)
    );

    assign fb.instr_valid = w_head_valid;

endmodule : nr_fetch_unit
`default_nettype wire
